pe_mac_ws: RTL and testbench

Parametrised weight-stationary MAC processing element for the systolic MAC array. Inputs flow top→down, partial sums flow left→right, and a valid bit travels with each operand. It generalises the fixed 8-bit PE with:
- configurable operand and partial-sum widths,
- a multi-bank weight store with glitch-free bank swap,
- a global stall,
- optional saturating accumulation with a sticky overflow flag.

---
 rtl/pe_pkg.sv | 41 ++++
 rtl/pe_weight_bank.sv | 39 +++
 rtl/pe_mac_ws.sv | 115 +++++++++++
 tb/tb_pe_mac_ws.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// pe_pkg: shared types and helpers for the weight-stationary MAC PE.
//   bank_w()  - width of a bank index, at least 1 bit
//   sat_add() - signed add of two sign-extended operands at a run-time width,
//               returning the saturated or wrapped result plus an overflow bit
package pe_pkg;

  // Widest partial sum the helpers can handle (result word width).
  localparam int MAX_W = 64;

  typedef struct packed {
    logic                    ovf;
    logic signed [MAX_W-1:0] val;
  } add_res_t;

  function automatic int bank_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // a and b must already be sign-extended w-bit values, so their sum fits in
  // w+1 bits and a range check equals "bit w differs from bit w-1".
  // The returned word is the w-bit result sign-extended to MAX_W.
  function automatic add_res_t sat_add(input logic signed [MAX_W-1:0] a,
                                       input logic signed [MAX_W-1:0] b,
                                       input int                      w,
                                       input logic                    sat);
    logic signed [MAX_W-1:0] sum;
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    logic signed [MAX_W-1:0] wrapped;
    add_res_t                res;
    sum     = a + b;
    hi      = (64'd1 << (w - 1)) - 64'd1;
    lo      = ~hi;
    wrapped = (sum <<< (MAX_W - w)) >>> (MAX_W - w);
    res.ovf = (sum > hi) || (sum < lo);
    if (res.ovf && sat) res.val = (sum > hi) ? hi : lo;
    else                res.val = wrapped;
    return res;
  endfunction

endpackage

// File: rtl/pe_weight_bank.sv
// pe_weight_bank: NUM_BANKS x W_W weight registers.
//   clk, rst_n        - clock, async active-low reset (clears all banks)
//   load/wr_bank/...  - write port; written value is readable next cycle
//   rd_bank/rd_data   - combinational read port
// Out-of-range bank indices write nothing and read zero.
module pe_weight_bank
  import pe_pkg::*;
#(
  parameter int W_W       = 8,
  parameter int NUM_BANKS = 2,
  parameter int BANK_W    = bank_w(NUM_BANKS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic [BANK_W-1:0]        wr_bank,
  input  logic signed [W_W-1:0]    wr_data,
  input  logic [BANK_W-1:0]        rd_bank,
  output logic signed [W_W-1:0]    rd_data
);

  logic signed [W_W-1:0] mem [NUM_BANKS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BANKS; i++) mem[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < NUM_BANKS; i++)
        if (int'(wr_bank) == i) mem[i] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_BANKS; i++)
      if (int'(rd_bank) == i) rd_data = mem[i];
  end

endmodule

// File: rtl/pe_mac_ws.sv
// pe_mac_ws: weight-stationary MAC processing element, 3-stage pipeline.
//   CLK, RSTN            - clock, async active-low reset
//   Stall                - freezes S1..S3 (inputs during stall are dropped)
//   Load/LoadBank/weight - weight store write (independent of Stall)
//   Swap / ActBank       - advance / current active bank (independent of Stall)
//   ITop/VTop -> ODown/VDown          - activation in, forwarded after 1 cycle
//   psumLeft  -> psumRight/VRight     - partial sum in (2 cycles after ITop),
//                                       result out 3 cycles after ITop
//   ClrOvf / Ovf         - clear / sticky overflow flag (set wins)
module pe_mac_ws
  import pe_pkg::*;
#(
  parameter int IN_W      = 8,
  parameter int W_W       = 8,
  parameter int PSUM_W    = 24,
  parameter int NUM_BANKS = 2,
  parameter int SAT       = 1,
  localparam int BANK_W   = bank_w(NUM_BANKS)
) (
  input  logic                     CLK,
  input  logic                     RSTN,
  input  logic                     Stall,
  input  logic                     Load,
  input  logic [BANK_W-1:0]        LoadBank,
  input  logic signed [W_W-1:0]    weight,
  input  logic                     Swap,
  input  logic signed [IN_W-1:0]   ITop,
  input  logic                     VTop,
  output logic signed [IN_W-1:0]   ODown,
  output logic                     VDown,
  input  logic signed [PSUM_W-1:0] psumLeft,
  output logic signed [PSUM_W-1:0] psumRight,
  output logic                     VRight,
  input  logic                     ClrOvf,
  output logic                     Ovf,
  output logic [BANK_W-1:0]        ActBank
);

  localparam int PROD_W = IN_W + W_W;

  if (PSUM_W < PROD_W + 1 || PSUM_W >= MAX_W) begin : g_bad_psum_w
    $error("pe_mac_ws: PSUM_W must be >= IN_W+W_W+1 and < %0d", MAX_W);
  end

  logic [BANK_W-1:0]        s1_tag;
  logic signed [W_W-1:0]    w_rd;
  logic signed [PROD_W-1:0] s2_prod;
  logic                     s2_v;
  logic signed [MAX_W-1:0]  prod_ext;
  logic signed [MAX_W-1:0]  left_ext;
  add_res_t                 sum_res;
  logic                     sum_ovf;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      ActBank <= '0;
    end else if (Swap && NUM_BANKS > 1) begin
      if (int'(ActBank) == NUM_BANKS - 1) ActBank <= '0;
      else                                ActBank <= ActBank + 1'b1;
    end
  end

  // Read is indexed by the S1 tag, so the weight is fetched at the S2 update
  // and a same-cycle Load to that bank is not yet visible.
  pe_weight_bank #(
    .W_W      (W_W),
    .NUM_BANKS(NUM_BANKS),
    .BANK_W   (BANK_W)
  ) u_bank (
    .clk    (CLK),
    .rst_n  (RSTN),
    .load   (Load),
    .wr_bank(LoadBank),
    .wr_data(weight),
    .rd_bank(s1_tag),
    .rd_data(w_rd)
  );

  assign prod_ext = {{(MAX_W-PROD_W){s2_prod[PROD_W-1]}}, s2_prod};
  assign left_ext = {{(MAX_W-PSUM_W){psumLeft[PSUM_W-1]}}, psumLeft};
  assign sum_res  = sat_add(prod_ext, left_ext, PSUM_W, SAT != 0);

  // Bits above PSUM_W are sign copies of the result by construction, so the
  // second term is constant zero; it keeps the whole returned word consumed.
  assign sum_ovf = sum_res.ovf |
                   (sum_res.val[MAX_W-1:PSUM_W] != {(MAX_W-PSUM_W){sum_res.val[PSUM_W-1]}});

  // ODown/VDown double as the S1 data/valid registers.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      ODown     <= '0;
      VDown     <= 1'b0;
      s1_tag    <= '0;
      s2_prod   <= '0;
      s2_v      <= 1'b0;
      psumRight <= '0;
      VRight    <= 1'b0;
    end else if (!Stall) begin
      ODown     <= ITop;
      VDown     <= VTop;
      s1_tag    <= ActBank;
      s2_prod   <= PROD_W'(ODown) * PROD_W'(w_rd);
      s2_v      <= VDown;
      psumRight <= s2_v ? sum_res.val[PSUM_W-1:0] : psumLeft;
      VRight    <= s2_v;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)                          Ovf <= 1'b0;
    else if (!Stall && s2_v && sum_ovf) Ovf <= 1'b1;
    else if (ClrOvf)                    Ovf <= 1'b0;
  end

endmodule

// File: tb/tb_pe_mac_ws.sv
module tb_pe_mac_ws;

  localparam int IN_W = 8;
  localparam int W_W  = 8;
  localparam int PW   = 17;
  localparam int NB   = 2;
  localparam int BW   = 1;
  localparam int PMAX = (1 << (PW - 1)) - 1;
  localparam int PMIN = -(1 << (PW - 1));

  logic CLK = 1'b0;
  logic RSTN = 1'b0;
  logic Stall = 1'b0, Load = 1'b0, Swap = 1'b0, VTop = 1'b0, ClrOvf = 1'b0;
  logic [BW-1:0]          LoadBank = '0;
  logic signed [W_W-1:0]  weight = '0;
  logic signed [IN_W-1:0] ITop = '0;
  logic signed [PW-1:0]   psumLeft = '0;

  logic signed [IN_W-1:0] od_s, od_w;
  logic                   vd_s, vd_w, vr_s, vr_w, ovf_s, ovf_w;
  logic signed [PW-1:0]   ps_s, ps_w;
  logic [BW-1:0]          act_s, act_w;

  pe_mac_ws #(.IN_W(IN_W), .W_W(W_W), .PSUM_W(PW), .NUM_BANKS(NB), .SAT(1)) u_sat (
    .CLK(CLK), .RSTN(RSTN), .Stall(Stall), .Load(Load), .LoadBank(LoadBank),
    .weight(weight), .Swap(Swap), .ITop(ITop), .VTop(VTop), .ODown(od_s),
    .VDown(vd_s), .psumLeft(psumLeft), .psumRight(ps_s), .VRight(vr_s),
    .ClrOvf(ClrOvf), .Ovf(ovf_s), .ActBank(act_s));

  pe_mac_ws #(.IN_W(IN_W), .W_W(W_W), .PSUM_W(PW), .NUM_BANKS(NB), .SAT(0)) u_wrap (
    .CLK(CLK), .RSTN(RSTN), .Stall(Stall), .Load(Load), .LoadBank(LoadBank),
    .weight(weight), .Swap(Swap), .ITop(ITop), .VTop(VTop), .ODown(od_w),
    .VDown(vd_w), .psumLeft(psumLeft), .psumRight(ps_w), .VRight(vr_w),
    .ClrOvf(ClrOvf), .Ovf(ovf_w), .ActBank(act_w));

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input int ld, input int lb, input int w, input int sw,
                       input int it, input int vt, input int pl, input int st,
                       input int clr);
    Load     = (ld != 0);
    LoadBank = BW'(lb);
    weight   = W_W'(w);
    Swap     = (sw != 0);
    ITop     = IN_W'(it);
    VTop     = (vt != 0);
    psumLeft = PW'(pl);
    Stall    = (st != 0);
    ClrOvf   = (clr != 0);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int a;
    int v;
    int bank;
    int prod;
  } op_t;

  op_t q[$];          // q[0]: op in the multiply stage, q[1]: op just captured
  int  m_w[NB];
  int  m_act, m_ps_s, m_ps_w, m_vr, m_ovf;

  function automatic int wrap_p(input int x);
    return ((x - PMIN) & ((1 << PW) - 1)) + PMIN;
  endfunction

  function automatic int sat_p(input int x);
    if (x > PMAX) return PMAX;
    if (x < PMIN) return PMIN;
    return x;
  endfunction

  task automatic model_reset();
    q.delete();
    q.push_back('{0, 0, 0, 0});
    q.push_back('{0, 0, 0, 0});
    foreach (m_w[i]) m_w[i] = 0;
    m_act = 0; m_ps_s = 0; m_ps_w = 0; m_vr = 0; m_ovf = 0;
  endtask

  task automatic model_step();
    op_t r;
    int  sum;
    int  ovf_now;
    ovf_now = 0;
    if (!Stall) begin
      r    = q.pop_front();
      m_vr = r.v;
      if (r.v != 0) begin
        sum     = r.prod + int'(psumLeft);
        ovf_now = (sum > PMAX || sum < PMIN) ? 1 : 0;
        m_ps_s  = sat_p(sum);
        m_ps_w  = wrap_p(sum);
      end else begin
        m_ps_s = int'(psumLeft);
        m_ps_w = int'(psumLeft);
      end
      q[0].prod = q[0].a * m_w[q[0].bank];
      q.push_back('{int'(ITop), int'(VTop), m_act, 0});
    end
    if (ovf_now != 0) m_ovf = 1;
    else if (ClrOvf)  m_ovf = 0;
    if (Load) m_w[int'(LoadBank)] = int'(weight);
    if (Swap) m_act = (m_act + 1) % NB;
  endtask

  task automatic cmp_model();
    chk("rnd_odown_s",  int'(od_s),  q[1].a);
    chk("rnd_odown_w",  int'(od_w),  q[1].a);
    chk("rnd_vdown",    int'(vd_s),  q[1].v);
    chk("rnd_psum_sat", int'(ps_s),  m_ps_s);
    chk("rnd_psum_wrap",int'(ps_w),  m_ps_w);
    chk("rnd_vright_s", int'(vr_s),  m_vr);
    chk("rnd_vright_w", int'(vr_w),  m_vr);
    chk("rnd_ovf_s",    int'(ovf_s), m_ovf);
    chk("rnd_ovf_w",    int'(ovf_w), m_ovf);
    chk("rnd_act",      int'(act_s), m_act);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int ld, lb, w, sw, it, vt, pl, clr;
    int od, vd, pss, psw, vr, ovf, act;
  } vec_t;

  function automatic vec_t mk(input int ld, input int lb, input int w, input int sw,
                              input int it, input int vt, input int pl, input int clr,
                              input int od, input int vd, input int pss, input int psw,
                              input int vr, input int ovf, input int act);
    vec_t v;
    v.ld = ld; v.lb = lb; v.w = w; v.sw = sw; v.it = it; v.vt = vt; v.pl = pl;
    v.clr = clr; v.od = od; v.vd = vd; v.pss = pss; v.psw = psw; v.vr = vr;
    v.ovf = ovf; v.act = act;
    return v;
  endfunction

  vec_t tbl[$];
  int   got_q[$];

  initial begin
    //                ld lb   w  sw   it vt     pl clr   od vd    pss     psw vr ovf act
    tbl.push_back(mk(1, 0,   3, 0,    0, 0,     0, 0,    0, 0,     0,      0, 0, 0, 0));
    tbl.push_back(mk(1, 1,  -2, 0,    5, 1,     0, 0,    5, 1,     0,      0, 0, 0, 0));
    tbl.push_back(mk(0, 0,   0, 0,    0, 0,     0, 0,    0, 0,     0,      0, 0, 0, 0));
    tbl.push_back(mk(0, 0,   0, 0,    0, 0,    10, 0,    0, 0,    25,     25, 1, 0, 0));
    tbl.push_back(mk(0, 0,   0, 1,    4, 1,     0, 0,    4, 1,     0,      0, 0, 0, 1));
    tbl.push_back(mk(0, 0,   0, 0,    4, 1,     0, 0,    4, 1,     0,      0, 0, 0, 1));
    tbl.push_back(mk(0, 0,   0, 0,    0, 0,     0, 0,    0, 0,    12,     12, 1, 0, 1));
    tbl.push_back(mk(0, 0,   0, 0,    0, 0,     0, 0,    0, 0,    -8,     -8, 1, 0, 1));
    tbl.push_back(mk(1, 1,   1, 0,    0, 0,     0, 0,    0, 0,     0,      0, 0, 0, 1));
    tbl.push_back(mk(0, 0,   0, 0,  127, 1,     0, 0,  127, 1,     0,      0, 0, 0, 1));
    tbl.push_back(mk(0, 0,   0, 0,    0, 0,     0, 0,    0, 0,     0,      0, 0, 0, 1));
    tbl.push_back(mk(0, 0,   0, 0,    0, 0, 65535, 0,    0, 0, 65535, -65410, 1, 1, 1));
    tbl.push_back(mk(1, 1,-128, 0,    0, 0,     0, 0,    0, 0,     0,      0, 0, 1, 1));
    tbl.push_back(mk(0, 0,   0, 0, -128, 1,     0, 1, -128, 1,     0,      0, 0, 0, 1));
    tbl.push_back(mk(0, 0,   0, 0,    0, 0,     0, 0,    0, 0,     0,      0, 0, 0, 1));
    tbl.push_back(mk(0, 0,   0, 0,    0, 0,     0, 0,    0, 0, 16384,  16384, 1, 0, 1));
    tbl.push_back(mk(1, 1,   1, 0,  127, 1,     0, 0,  127, 1,     0,      0, 0, 0, 1));
    tbl.push_back(mk(0, 0,   0, 0,    0, 0,     0, 0,    0, 0,     0,      0, 0, 0, 1));
    tbl.push_back(mk(0, 0,   0, 0,    0, 0, 65535, 1,    0, 0, 65535, -65410, 1, 1, 1));
    tbl.push_back(mk(0, 0,   0, 0,    0, 0,     0, 1,    0, 0,     0,      0, 0, 0, 1));
    tbl.push_back(mk(0, 0,   0, 0,   10, 1,     0, 0,   10, 1,     0,      0, 0, 0, 1));
    tbl.push_back(mk(1, 1,   5, 0,    0, 0,     0, 0,    0, 0,     0,      0, 0, 0, 1));
    tbl.push_back(mk(0, 0,   0, 0,    0, 0,     0, 0,    0, 0,    10,     10, 1, 0, 1));
    tbl.push_back(mk(0, 0,   0, 1,    0, 0,     0, 0,    0, 0,     0,      0, 0, 0, 0));

    // reset state
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    RSTN = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RSTN = 1'b1;
    chk("rst_odown",  int'(od_s),  0);
    chk("rst_vdown",  int'(vd_s),  0);
    chk("rst_psum",   int'(ps_s),  0);
    chk("rst_vright", int'(vr_s),  0);
    chk("rst_ovf",    int'(ovf_s), 0);
    chk("rst_act",    int'(act_s), 0);

    foreach (tbl[i]) begin
      drive(tbl[i].ld, tbl[i].lb, tbl[i].w, tbl[i].sw, tbl[i].it, tbl[i].vt,
            tbl[i].pl, 0, tbl[i].clr);
      tick();
      chk($sformatf("tbl%0d_odown", i),     int'(od_s),  tbl[i].od);
      chk($sformatf("tbl%0d_vdown", i),     int'(vd_s),  tbl[i].vd);
      chk($sformatf("tbl%0d_psum_sat", i),  int'(ps_s),  tbl[i].pss);
      chk($sformatf("tbl%0d_psum_wrap", i), int'(ps_w),  tbl[i].psw);
      chk($sformatf("tbl%0d_vright", i),    int'(vr_s),  tbl[i].vr);
      chk($sformatf("tbl%0d_ovf_s", i),     int'(ovf_s), tbl[i].ovf);
      chk($sformatf("tbl%0d_ovf_w", i),     int'(ovf_w), tbl[i].ovf);
      chk($sformatf("tbl%0d_act", i),       int'(act_s), tbl[i].act);
    end

    // stall: stream 1,2,3 with weight 2, two stalled cycles mid-stream
    drive(1, 0, 2, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 1, 0, 0, 0); tick();
    if (vr_s) got_q.push_back(int'(ps_s));
    drive(0, 0, 0, 0, 2, 1, 0, 0, 0); tick();
    if (vr_s) got_q.push_back(int'(ps_s));
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 0, 0, 99, 1, 7, 1, 0); tick();
      chk("stall_odown",  int'(od_s), 2);
      chk("stall_vdown",  int'(vd_s), 1);
      chk("stall_psum",   int'(ps_s), 0);
      chk("stall_vright", int'(vr_s), 0);
    end
    drive(0, 0, 0, 0, 3, 1, 0, 0, 0); tick();
    if (vr_s) got_q.push_back(int'(ps_s));
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
      if (vr_s) got_q.push_back(int'(ps_s));
    end
    chk("stall_count", got_q.size(), 3);
    for (int k = 0; k < 3; k++)
      chk($sformatf("stall_out%0d", k), (k < got_q.size()) ? got_q[k] : -1, 2 * (k + 1));

    // reset mid-stream
    drive(1, 1, 2, 1, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 5, 1, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 6, 1, 0, 0, 0); tick();
    chk("pre_rst_odown", int'(od_s),  6);
    chk("pre_rst_act",   int'(act_s), 1);
    #2;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    RSTN = 1'b0;
    #1;
    chk("midrst_odown",  int'(od_s),  0);
    chk("midrst_vdown",  int'(vd_s),  0);
    chk("midrst_psum",   int'(ps_s),  0);
    chk("midrst_vright", int'(vr_s),  0);
    chk("midrst_act",    int'(act_s), 0);
    @(posedge CLK);
    #1 RSTN = 1'b1;
    drive(1, 0, 2, 0, 0, 0, 0, 0, 0); tick();
    chk("post_rst_vr0", int'(vr_s), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    chk("post_rst_vr1", int'(vr_s), 0);
    drive(0, 0, 0, 0, 7, 1, 0, 0, 0); tick();
    chk("post_rst_vr2", int'(vr_s), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    chk("post_rst_vr3", int'(vr_s), 0);
    tick();
    chk("post_rst_vr4",   int'(vr_s), 1);
    chk("post_rst_psum4", int'(ps_s), 14);

    // randomized run against the reference model
    RSTN = 1'b0;
    #2;
    RSTN = 1'b1;
    model_reset();
    for (int n = 0; n < 600; n++) begin
      int sel, pl;
      sel = int'($urandom_range(0, 3));
      if (sel == 0)      pl = PMAX - int'($urandom_range(0, 300));
      else if (sel == 1) pl = PMIN + int'($urandom_range(0, 300));
      else               pl = int'($urandom_range(0, (1 << PW) - 1)) + PMIN;
      drive(($urandom_range(0, 9) < 3) ? 1 : 0,
            int'($urandom_range(0, NB - 1)),
            int'($urandom_range(0, 255)) - 128,
            ($urandom_range(0, 9) == 0) ? 1 : 0,
            int'($urandom_range(0, 255)) - 128,
            ($urandom_range(0, 9) < 7) ? 1 : 0,
            pl,
            ($urandom_range(0, 99) < 15) ? 1 : 0,
            ($urandom_range(0, 9) == 0) ? 1 : 0);
      model_step();
      tick();
      cmp_model();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
